// File: rtl/debug_controller.sv
// Debug unit: NUM_BP PC breakpoints, NUM_WP read/write watchpoints, halt/step/resume
// command handshake, and a circular instruction trace with oldest-first indexed readback.
module debug_controller #(
  parameter int ADDR_W   = 8,
  parameter int INST_W   = 16,
  parameter int NUM_BP   = 4,
  parameter int NUM_WP   = 2,
  parameter int TRACE_AW = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [INST_W-1:0]        instruction,
  input  logic                     inst_valid,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic                     debug_enable,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic [NUM_WP*ADDR_W-1:0] wp_addr,
  input  logic [2*NUM_WP-1:0]      wp_mode,
  input  logic                     cmd_halt,
  input  logic                     cmd_step,
  input  logic                     cmd_resume,
  input  logic                     trace_enable,
  input  logic                     trace_clear,
  input  logic [TRACE_AW-1:0]      trace_rd_idx,
  output logic                     debug_halt,
  output logic [2:0]               halt_cause,
  output logic [2:0]               hit_id,
  output logic                     step_done,
  output logic [ADDR_W-1:0]        trace_rd_pc,
  output logic [INST_W-1:0]        trace_rd_inst,
  output logic [TRACE_AW:0]        trace_count,
  output logic                     trace_wrapped
);

  localparam int DEPTH = 2 ** TRACE_AW;
  localparam logic [TRACE_AW:0] FULL = (TRACE_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_HALTED, S_STEP} state_t;

  state_t            state;
  logic              skip_bp;
  logic [ADDR_W-1:0] skip_pc;
  logic              skip_active;
  logic              bp_hit, wp_hit;
  logic [2:0]        bp_idx, wp_idx;

  // Ascending scan with first-hit latch gives lowest index priority.
  always_comb begin
    bp_hit = 1'b0;
    bp_idx = '0;
    for (int unsigned k = 0; k < NUM_BP; k++) begin
      if (!bp_hit && bp_en[k] && pc == bp_addr[k*ADDR_W +: ADDR_W]) begin
        bp_hit = 1'b1;
        bp_idx = 3'(k);
      end
    end
    wp_hit = 1'b0;
    wp_idx = '0;
    for (int unsigned k = 0; k < NUM_WP; k++) begin
      if (!wp_hit && mem_addr == wp_addr[k*ADDR_W +: ADDR_W] &&
          ((wp_mode[2*k] && mem_read) || (wp_mode[2*k+1] && mem_write))) begin
        wp_hit = 1'b1;
        wp_idx = 3'(k);
      end
    end
  end

  // Suppression only applies while pc still equals the resume PC, so the cycle
  // the PC moves on is already eligible for a fresh breakpoint hit.
  assign skip_active = skip_bp && (pc == skip_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      debug_halt <= 1'b0;
      halt_cause <= '0;
      hit_id     <= '0;
      step_done  <= 1'b0;
      skip_bp    <= 1'b0;
      skip_pc    <= '0;
    end else if (!debug_enable) begin
      state      <= S_RUN;
      debug_halt <= 1'b0;
      halt_cause <= '0;
      hit_id     <= '0;
      step_done  <= 1'b0;
      skip_bp    <= 1'b0;
    end else begin
      step_done <= 1'b0;
      if (skip_bp && pc != skip_pc) skip_bp <= 1'b0;
      case (state)
        S_RUN: begin
          if (bp_hit && !skip_active) begin
            state <= S_HALTED; debug_halt <= 1'b1; halt_cause <= 3'd1; hit_id <= bp_idx;
          end else if (wp_hit) begin
            state <= S_HALTED; debug_halt <= 1'b1; halt_cause <= 3'd2; hit_id <= wp_idx;
          end else if (cmd_halt) begin
            state <= S_HALTED; debug_halt <= 1'b1; halt_cause <= 3'd3; hit_id <= '0;
          end
        end
        S_HALTED: begin
          if (cmd_step) begin
            state      <= S_STEP;
            debug_halt <= 1'b0;
          end else if (cmd_resume) begin
            state      <= S_RUN;
            debug_halt <= 1'b0;
            halt_cause <= '0;
            hit_id     <= '0;
            if (halt_cause == 3'd1) begin
              skip_bp <= 1'b1;
              skip_pc <= pc;
            end
          end
        end
        S_STEP: begin
          if (wp_hit) begin
            state <= S_HALTED; debug_halt <= 1'b1; halt_cause <= 3'd2; hit_id <= wp_idx;
          end else if (inst_valid) begin
            state <= S_HALTED; debug_halt <= 1'b1; halt_cause <= 3'd4; hit_id <= '0;
            step_done <= 1'b1;
          end else if (cmd_resume) begin
            state <= S_RUN; halt_cause <= '0; hit_id <= '0;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

  logic [ADDR_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0]   inst_mem [DEPTH];
  logic [TRACE_AW-1:0] wr_ptr;
  logic [TRACE_AW-1:0] rd_phys;
  logic                trace_we;
  logic                rd_in_range;

  assign trace_we    = trace_enable && inst_valid && !trace_clear;
  assign rd_phys     = wr_ptr - trace_count[TRACE_AW-1:0] + trace_rd_idx;
  assign rd_in_range = {1'b0, trace_rd_idx} < trace_count;

  always_ff @(posedge clk) begin
    if (rst || trace_clear) begin
      wr_ptr        <= '0;
      trace_count   <= '0;
      trace_wrapped <= 1'b0;
    end else if (trace_we) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (trace_count == FULL) trace_wrapped <= 1'b1;
      else                     trace_count   <= trace_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (trace_we) begin
      pc_mem[wr_ptr]   <= pc;
      inst_mem[wr_ptr] <= instruction;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !rd_in_range) begin
      trace_rd_pc   <= '0;
      trace_rd_inst <= '0;
    end else begin
      trace_rd_pc   <= pc_mem[rd_phys];
      trace_rd_inst <= inst_mem[rd_phys];
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller: table of per-cycle bp/wp vectors, then
// hand-written step, trace, clear, reset and debug_enable sequences.
module tb_debug_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc;
  logic [15:0] instruction;
  logic        inst_valid;
  logic [7:0]  mem_addr;
  logic        mem_read, mem_write;
  logic        debug_enable;
  logic [31:0] bp_addr;
  logic [3:0]  bp_en;
  logic [15:0] wp_addr;
  logic [3:0]  wp_mode;
  logic        cmd_halt, cmd_step, cmd_resume;
  logic        trace_enable, trace_clear;
  logic [3:0]  trace_rd_idx;
  logic        debug_halt;
  logic [2:0]  halt_cause, hit_id;
  logic        step_done;
  logic [7:0]  trace_rd_pc;
  logic [15:0] trace_rd_inst;
  logic [4:0]  trace_count;
  logic        trace_wrapped;

  int errors = 0;
  int checks = 0;

  debug_controller #(.ADDR_W(8), .INST_W(16), .NUM_BP(4), .NUM_WP(2), .TRACE_AW(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instruction(instruction), .inst_valid(inst_valid),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .debug_enable(debug_enable), .bp_addr(bp_addr), .bp_en(bp_en),
    .wp_addr(wp_addr), .wp_mode(wp_mode), .cmd_halt(cmd_halt), .cmd_step(cmd_step),
    .cmd_resume(cmd_resume), .trace_enable(trace_enable), .trace_clear(trace_clear),
    .trace_rd_idx(trace_rd_idx), .debug_halt(debug_halt), .halt_cause(halt_cause),
    .hit_id(hit_id), .step_done(step_done), .trace_rd_pc(trace_rd_pc),
    .trace_rd_inst(trace_rd_inst), .trace_count(trace_count), .trace_wrapped(trace_wrapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] maddr;
    logic [3:0] ctl;  // {mem_read, mem_write, cmd_halt, cmd_resume}
    logic       exp_halt;
    logic [2:0] exp_cause;
    logic [2:0] exp_hit;
  } vec_t;

  function automatic vec_t v(input logic [7:0] p, input logic [7:0] m, input logic [3:0] c,
                             input logic eh, input logic [2:0] ec, input logic [2:0] ei);
    vec_t r;
    r.pc = p; r.maddr = m; r.ctl = c; r.exp_halt = eh; r.exp_cause = ec; r.exp_hit = ei;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    cmd_halt = 1'b0; cmd_step = 1'b0; cmd_resume = 1'b0;
    inst_valid = 1'b0; trace_clear = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  vec_t vecs [21];
  logic [3:0] rd_idx_tab [4];

  initial begin
    vecs[0]  = v(8'h1E, 8'h00, 4'b0000, 1'b0, 3'd0, 3'd0);
    vecs[1]  = v(8'h1F, 8'h00, 4'b0000, 1'b0, 3'd0, 3'd0);
    vecs[2]  = v(8'h20, 8'h00, 4'b0000, 1'b1, 3'd1, 3'd1);
    vecs[3]  = v(8'h20, 8'h00, 4'b0000, 1'b1, 3'd1, 3'd1);
    vecs[4]  = v(8'h20, 8'h00, 4'b0001, 1'b0, 3'd0, 3'd0);
    vecs[5]  = v(8'h20, 8'h00, 4'b0000, 1'b0, 3'd0, 3'd0);
    vecs[6]  = v(8'h21, 8'h00, 4'b0000, 1'b0, 3'd0, 3'd0);
    vecs[7]  = v(8'h20, 8'h00, 4'b0000, 1'b1, 3'd1, 3'd1);
    vecs[8]  = v(8'h20, 8'h00, 4'b0010, 1'b1, 3'd1, 3'd1);
    vecs[9]  = v(8'h22, 8'h00, 4'b0001, 1'b0, 3'd0, 3'd0);
    vecs[10] = v(8'h22, 8'h40, 4'b1000, 1'b0, 3'd0, 3'd0);
    vecs[11] = v(8'h22, 8'h40, 4'b0100, 1'b1, 3'd2, 3'd0);
    vecs[12] = v(8'h22, 8'h00, 4'b0001, 1'b0, 3'd0, 3'd0);
    vecs[13] = v(8'h22, 8'h44, 4'b0100, 1'b0, 3'd0, 3'd0);
    vecs[14] = v(8'h22, 8'h44, 4'b1000, 1'b1, 3'd2, 3'd1);
    vecs[15] = v(8'h22, 8'h00, 4'b0001, 1'b0, 3'd0, 3'd0);
    vecs[16] = v(8'h30, 8'h40, 4'b0100, 1'b1, 3'd1, 3'd2);
    vecs[17] = v(8'h30, 8'h00, 4'b0001, 1'b0, 3'd0, 3'd0);
    vecs[18] = v(8'h10, 8'h00, 4'b0000, 1'b0, 3'd0, 3'd0);
    vecs[19] = v(8'h11, 8'h00, 4'b0010, 1'b1, 3'd3, 3'd0);
    vecs[20] = v(8'h11, 8'h00, 4'b0001, 1'b0, 3'd0, 3'd0);
    rd_idx_tab[0] = 4'd0; rd_idx_tab[1] = 4'd15; rd_idx_tab[2] = 4'd5; rd_idx_tab[3] = 4'd10;

    rst = 1'b1; pc = '0; instruction = '0; mem_addr = '0; debug_enable = 1'b1;
    bp_addr = {8'h30, 8'h30, 8'h20, 8'h10};
    bp_en   = 4'b1110;
    wp_addr = {8'h44, 8'h40};
    wp_mode = {2'b01, 2'b10};
    trace_enable = 1'b0; trace_rd_idx = '0;
    clear_pulses();
    tick(); tick();
    check("rst_halt", debug_halt, 0);
    check("rst_cause", halt_cause, 0);
    check("rst_hit", hit_id, 0);
    check("rst_step_done", step_done, 0);
    check("rst_count", trace_count, 0);
    check("rst_wrapped", trace_wrapped, 0);
    check("rst_rd_pc", trace_rd_pc, 0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      pc = vecs[i].pc; mem_addr = vecs[i].maddr;
      {mem_read, mem_write, cmd_halt, cmd_resume} = vecs[i].ctl;
      tick();
      check($sformatf("vec%0d_halt", i), debug_halt, vecs[i].exp_halt);
      check($sformatf("vec%0d_cause", i), halt_cause, vecs[i].exp_cause);
      check($sformatf("vec%0d_hit", i), hit_id, vecs[i].exp_hit);
    end
    clear_pulses();

    // single step with a delayed retire
    cmd_halt = 1'b1; tick(); clear_pulses();
    check("step_pre_halt", debug_halt, 1);
    cmd_step = 1'b1; tick(); clear_pulses();
    check("step_run_halt", debug_halt, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("step_wait_halt", debug_halt, 0);
      check("step_wait_done", step_done, 0);
    end
    inst_valid = 1'b1; tick(); clear_pulses();
    check("step_done_halt", debug_halt, 1);
    check("step_done_cause", halt_cause, 4);
    check("step_done_hit", hit_id, 0);
    check("step_done_pulse", step_done, 1);
    tick();
    check("step_done_clear", step_done, 0);
    check("step_still_halt", debug_halt, 1);

    // step+resume together: step wins, so bp at 0x20 is ignored
    pc = 8'h20; cmd_step = 1'b1; cmd_resume = 1'b1; tick(); clear_pulses();
    check("stepres_halt", debug_halt, 0);
    tick();
    check("stepres_bp_ignored", debug_halt, 0);
    inst_valid = 1'b1; tick(); clear_pulses();
    check("stepres_done", step_done, 1);
    check("stepres_cause", halt_cause, 4);

    // resume out of STEP returns to RUN where the bp fires
    cmd_step = 1'b1; tick(); clear_pulses();
    cmd_resume = 1'b1; tick(); clear_pulses();
    check("step_resume_halt", debug_halt, 0);
    tick();
    check("step_resume_bp_halt", debug_halt, 1);
    check("step_resume_bp_cause", halt_cause, 1);
    check("step_resume_bp_hit", hit_id, 1);

    // debug_enable low drops a halt and suppresses bp
    debug_enable = 1'b0; tick();
    check("den_halt_drop", debug_halt, 0);
    check("den_cause_clr", halt_cause, 0);
    tick();
    check("den_no_bp", debug_halt, 0);

    // trace wrap: 20 entries into 16-deep buffer
    trace_clear = 1'b1; tick(); clear_pulses();
    trace_enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pc = 8'(i); instruction = 16'hA000 + 16'(i); inst_valid = 1'b1; tick();
    end
    clear_pulses();
    check("wrap_count", trace_count, 16);
    check("wrap_flag", trace_wrapped, 1);
    for (int i = 0; i < 4; i++) begin
      trace_rd_idx = rd_idx_tab[i]; tick();
      check($sformatf("wrap_rd_pc_idx%0d", rd_idx_tab[i]), trace_rd_pc, 32'(rd_idx_tab[i]) + 4);
      check($sformatf("wrap_rd_inst_idx%0d", rd_idx_tab[i]), trace_rd_inst, 32'h0000A004 + 32'(rd_idx_tab[i]));
    end

    // partial buffer: out-of-range index reads zero
    trace_clear = 1'b1; tick(); clear_pulses();
    for (int i = 0; i < 5; i++) begin
      pc = 8'h60 + 8'(i); instruction = 16'hB000 + 16'(i); inst_valid = 1'b1; tick();
    end
    clear_pulses();
    check("part_count", trace_count, 5);
    check("part_wrapped", trace_wrapped, 0);
    trace_rd_idx = 4'd7; tick();
    check("part_idx7_pc", trace_rd_pc, 0);
    check("part_idx7_inst", trace_rd_inst, 0);
    trace_rd_idx = 4'd5; tick();
    check("part_idx5_pc", trace_rd_pc, 0);
    trace_rd_idx = 4'd4; tick();
    check("part_idx4_pc", trace_rd_pc, 8'h64);
    check("part_idx4_inst", trace_rd_inst, 16'hB004);
    trace_rd_idx = 4'd0; tick();
    check("part_idx0_pc", trace_rd_pc, 8'h60);

    // clear beats a same-cycle write
    trace_clear = 1'b1; inst_valid = 1'b1; tick(); clear_pulses();
    check("clr_count", trace_count, 0);
    check("clr_wrapped", trace_wrapped, 0);
    tick();
    check("clr_rd_pc", trace_rd_pc, 0);

    // reset while halted with a non-empty trace
    debug_enable = 1'b1; pc = 8'h70; inst_valid = 1'b1; tick(); clear_pulses();
    check("prerst_count", trace_count, 1);
    cmd_halt = 1'b1; tick(); clear_pulses();
    check("prerst_halt", debug_halt, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_halt", debug_halt, 0);
    check("midrst_cause", halt_cause, 0);
    check("midrst_count", trace_count, 0);
    tick();
    check("postrst_halt", debug_halt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
